// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and the shift register it drives.
// Holds the shift-register mode encodings, the command opcode encodings,
// the FSM state enum and a helper that tells legal opcodes from illegal ones.
package shift_sequencer_pkg;

  // Shift-register mode select values
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // Command opcodes; 6 and 7 are illegal
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_ASR;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command handshake bundle for the shift sequencer.
//   cmd_valid/cmd_ready : valid/ready handshake, accepted when both are high
//   cmd_op              : operation code
//   cmd_count           : shift amount in bits
//   cmd_data            : parallel-load value
//   cmd_fill            : serial fill bit for SHL/SHR
// master drives commands, slave (the sequencer) accepts them.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
    output cmd_ready
  );

endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register used as the controlled datapath.
// Ports:
//   clk, sync_reset           : clock and synchronous active-low reset (clears q)
//   sr_sel                    : 00 hold, 01 shift right, 10 shift left, 11 load
//   load_data                 : parallel-load value
//   rightshift / leftshift    : serial inputs entering MSB / bit 0
//   q                         : register contents
module universal_shift_reg
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [1:0]       sr_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             rightshift,
  input  logic             leftshift,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      q <= '0;
    end else begin
      case (sr_sel)
        SEL_SHR:  q <= {rightshift, q[WIDTH-1:1]};
        SEL_SHL:  q <= {q[WIDTH-2:0], leftshift};
        SEL_LOAD: q <= load_data;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an external universal shift register.
// Accepts one command at a time, steers the register through a parallel load
// or a multi-cycle shift/rotate, then reports the register value.
// Ports:
//   clk, sync_reset           : clock, synchronous active-low reset
//   cmd                       : command handshake (slave modport)
//   sr_sel, sr_load_data      : shift-register mode and load value
//   sr_rightshift/leftshift   : serial inputs for the shift register
//   sr_q                      : current shift-register contents
//   busy, done, err, result   : status and completion value
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             sync_reset,
  shift_sequencer_if.slave cmd,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_load_data,
  output logic             sr_rightshift,
  output logic             sr_leftshift,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] remain_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic [CNT_W-1:0] count_clamped;

  assign accept = cmd.cmd_valid && (state_q == ST_IDLE);

  // Shifting more than WIDTH bits is pointless, so the count saturates at WIDTH
  assign count_clamped = (cmd.cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd.cmd_count;

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      remain_q <= '0;
      data_q   <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= cmd.cmd_op;
        remain_q <= count_clamped;
        data_q   <= cmd.cmd_data;
        fill_q   <= cmd.cmd_fill;
      end else if (state_q == ST_SHIFT) begin
        remain_q <= remain_q - CNT_W'(1);
      end
      if (state_q == ST_DONE) begin
        result_q <= sr_q;
      end
    end
  end

  // Next-state logic: illegal ops and zero-length shifts skip straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_legal_op(cmd.cmd_op)) begin
            state_d = ST_DONE;
          end else if (cmd.cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (cmd.cmd_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (remain_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath steering: rotates and ASR feed the register's own edge bits back in
  always_comb begin
    sr_sel        = SEL_HOLD;
    sr_load_data  = '0;
    sr_rightshift = 1'b0;
    sr_leftshift  = 1'b0;
    if (state_q == ST_LOAD) begin
      sr_sel       = SEL_LOAD;
      sr_load_data = data_q;
    end else if (state_q == ST_SHIFT) begin
      case (op_q)
        OP_SHL: begin
          sr_sel       = SEL_SHL;
          sr_leftshift = fill_q;
        end
        OP_SHR: begin
          sr_sel        = SEL_SHR;
          sr_rightshift = fill_q;
        end
        OP_ROL: begin
          sr_sel       = SEL_SHL;
          sr_leftshift = sr_q[WIDTH-1];
        end
        OP_ROR: begin
          sr_sel        = SEL_SHR;
          sr_rightshift = sr_q[0];
        end
        OP_ASR: begin
          sr_sel        = SEL_SHR;
          sr_rightshift = sr_q[WIDTH-1];
        end
        default: sr_sel = SEL_HOLD;
      endcase
    end
  end

  // Result is live during DONE and held from the last DONE otherwise
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err           = (state_q == ST_DONE) && !is_legal_op(op_q);
  assign result        = (state_q == ST_DONE) ? sr_q : result_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the controlled shift register.
REQ-002 Parameter CNT_W, default 4 (clog2(WIDTH)+1), SHALL set the width of the shift-count field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 sync_reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 cmd_valid  input  1  SHALL indicate that a command is presented.
REQ-006 cmd_ready  output  1  SHALL indicate that the block can accept a command.
REQ-007 cmd_op  input  3  SHALL select the operation: 0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR; 6 and 7 are illegal.
REQ-008 cmd_count  input  CNT_W  SHALL give the shift amount in bits.
REQ-009 cmd_data  input  WIDTH  SHALL give the parallel-load value.
REQ-010 cmd_fill  input  1  SHALL give the serial fill bit for SHL and SHR.
REQ-011 sr_sel  output  2  SHALL be the shift-register mode: 00 hold, 01 shift right (MSB takes sr_rightshift), 10 shift left (bit0 takes sr_leftshift), 11 parallel load.
REQ-012 sr_load_data  output  WIDTH  SHALL carry the parallel-load value to the shift register.
REQ-013 sr_rightshift  output  1  SHALL be the serial input used during a right shift.
REQ-014 sr_leftshift  output  1  SHALL be the serial input used during a left shift.
REQ-015 sr_q  input  WIDTH  SHALL be the current contents of the shift register.
REQ-016 busy, done, err, result[WIDTH]  outputs: busy SHALL be high whenever the state is not IDLE; done SHALL be a 1-cycle completion pulse; err SHALL flag an illegal op and coincide with done; result SHALL carry the completion value.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE; cmd_ready SHALL equal 1 only in IDLE.
REQ-018 A command SHALL be accepted at the edge where cmd_valid=1 and cmd_ready=1 (acceptance cycle T); op, count, data and fill SHALL be latched at that edge.
REQ-019 From IDLE, LOAD SHALL go to LOAD, SHIFT-class ops with count>0 SHALL go to SHIFT, and count=0 or an illegal op SHALL go directly to DONE.
REQ-020 LOAD state SHALL last one cycle (T+1) with sr_sel=11 and sr_load_data equal to the latched data, then go to DONE (T+2).
REQ-021 SHIFT SHALL assert the shift sel for n consecutive cycles (T+1..T+n), decrementing the remaining count each cycle, then go to DONE at T+n+1.
REQ-022 n SHALL be min(cmd_count, WIDTH) for every shift op, so ROL/ROR by WIDTH returns the original value.
REQ-023 Serial inputs: SHL leftshift=fill; SHR rightshift=fill; ROL leftshift=sr_q[WIDTH-1]; ROR rightshift=sr_q[0]; ASR rightshift=sr_q[WIDTH-1]; unused serial inputs SHALL be 0.
REQ-024 sr_sel SHALL be 00 in IDLE and DONE, and throughout any illegal-op command.
REQ-025 DONE SHALL last exactly one cycle: done=1, result=sr_q, err=1 only for an illegal op; the next state SHALL be IDLE.
REQ-026 Outside DONE, result SHALL hold the value captured in the most recent DONE cycle.
REQ-027 The minimum command period SHALL be 2 cycles for count=0 and illegal ops, 3 cycles for LOAD, and n+2 cycles for a shift by n.
REQ-028 cmd_valid asserted while busy SHALL be ignored and SHALL NOT be latched.

Reset
REQ-029 When sync_reset=0 at a clock edge, the block SHALL enter IDLE; sr_sel=00, serial outputs=0, sr_load_data=0, result=0, done=0, err=0, busy=0 and cmd_ready=1 SHALL hold from the next cycle.
REQ-030 Reset SHALL override any state, including mid-SHIFT; no done pulse SHALL be issued for the aborted command.

Structure
REQ-031 A shared package SHALL hold the sr_sel encodings, the cmd_op encodings and the FSM state enum.
REQ-032 The block SHALL be a single module with no sub-module; the bench SHALL instantiate the team's WIDTH-bit universal shift register as the controlled datapath.

Verification (WIDTH=8)
REQ-033 LOAD 0xA5 accepted at T -> sr_sel=11 at T+1; done=1 and result=0xA5 at T+2.
REQ-034 LOAD 0x81, then ROL count 3 -> three cycles with sr_sel=10; done at T+4 with result=0x0C.
REQ-035 After LOAD 0x90, ASR count 2 -> result=0xE4 and err=0.
REQ-036 After LOAD 0x00, SHL fill=1 count 12 -> exactly 8 shift cycles; result=0xFF.
REQ-037 cmd_op=6 -> done=1 and err=1 at T+1, sr_sel=00 in every cycle, register contents unchanged.
REQ-038 sync_reset=0 during the third cycle of a count-5 SHIFT -> IDLE with sr_sel=00, busy=0 and no done pulse; the next command is accepted normally.
